// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the RV32I pipeline.
// Non-memory ops retire their ALU result one cycle after accept. Loads and
// stores move one byte per acked cycle over the byte-serial memory port,
// little-endian, then retire through the register write port.
//
// Ports:
//   clk, rst                  clock, synchronous active-low reset
//   in_valid / in_ready       EX handshake (in_ready = idle)
//   in_wreg, in_wd, in_wdata  rd write enable, address, ALU result
//   in_mem_op                 0 none, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU,
//                             6 SB, 7 SH, 8 SW, others none
//   in_mem_addr, in_store_data  effective address, store source
//   mem_req/we/addr/wdata     registered byte request, held until acked
//   mem_ack, mem_rdata        byte completion, read byte
//   stall_req                 high during every access cycle
//   wb_valid, w_enable, w_addr, w_data  retire pulse and register write
module mem_stage #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_wreg,
    input  logic [REG_AW-1:0] in_wd,
    input  logic [DATA_W-1:0] in_wdata,
    input  logic [3:0]        in_mem_op,
    input  logic [ADDR_W-1:0] in_mem_addr,
    input  logic [DATA_W-1:0] in_store_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic              mem_ack,
    input  logic [7:0]        mem_rdata,
    output logic              stall_req,
    output logic              wb_valid,
    output logic              w_enable,
    output logic [REG_AW-1:0] w_addr,
    output logic [DATA_W-1:0] w_data
);
    localparam logic [3:0] OP_LB = 4'd1, OP_LH = 4'd2, OP_LW = 4'd3, OP_LBU = 4'd4,
                           OP_LHU = 4'd5, OP_SB = 4'd6, OP_SH = 4'd7, OP_SW = 4'd8;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    typedef struct packed {
        logic              wreg;
        logic [REG_AW-1:0] wd;
        logic [3:0]        op;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] sdata;
    } req_t;

    // Byte count of an access; 0 means no memory access.
    function automatic logic [2:0] op_len(input logic [3:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return 3'd1;
            OP_LH, OP_LHU, OP_SH: return 3'd2;
            OP_LW, OP_SW:         return 3'd4;
            default:              return 3'd0;
        endcase
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic [DATA_W-1:0] load_ext(input logic [3:0] op, input logic [31:0] b);
        case (op)
            OP_LB:   return {{(DATA_W-8){b[7]}}, b[7:0]};
            OP_LH:   return {{(DATA_W-16){b[15]}}, b[15:0]};
            OP_LBU:  return {{(DATA_W-8){1'b0}}, b[7:0]};
            OP_LHU:  return {{(DATA_W-16){1'b0}}, b[15:0]};
            default: return DATA_W'(b);
        endcase
    endfunction

    state_t            state, state_n;
    req_t              req, req_n;
    logic [1:0]        cnt, cnt_n;
    logic [31:0]       rbuf, rbuf_n;
    logic              mem_req_n, mem_we_n, stall_n;
    logic [ADDR_W-1:0] mem_addr_n;
    logic [7:0]        mem_wdata_n;
    logic              wb_valid_n, w_enable_n;
    logic [REG_AW-1:0] w_addr_n;
    logic [DATA_W-1:0] w_data_n;

    // Bit offsets of the current byte and of the byte after it.
    logic [4:0]  rd_idx, nx_idx;
    logic [31:0] sdata_w;
    assign rd_idx  = {cnt, 3'b000};
    assign nx_idx  = {cnt + 2'd1, 3'b000};
    assign sdata_w = req.sdata[31:0];

    assign in_ready = (state == IDLE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            req       <= '0;
            cnt       <= '0;
            rbuf      <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            stall_req <= 1'b0;
            wb_valid  <= 1'b0;
            w_enable  <= 1'b0;
            w_addr    <= '0;
            w_data    <= '0;
        end else begin
            state     <= state_n;
            req       <= req_n;
            cnt       <= cnt_n;
            rbuf      <= rbuf_n;
            mem_req   <= mem_req_n;
            mem_we    <= mem_we_n;
            mem_addr  <= mem_addr_n;
            mem_wdata <= mem_wdata_n;
            stall_req <= stall_n;
            wb_valid  <= wb_valid_n;
            w_enable  <= w_enable_n;
            w_addr    <= w_addr_n;
            w_data    <= w_data_n;
        end
    end

    always_comb begin
        state_n     = state;
        req_n       = req;
        cnt_n       = cnt;
        rbuf_n      = rbuf;
        mem_req_n   = mem_req;
        mem_we_n    = mem_we;
        mem_addr_n  = mem_addr;
        mem_wdata_n = mem_wdata;
        stall_n     = stall_req;
        wb_valid_n  = 1'b0;
        w_enable_n  = 1'b0;
        w_addr_n    = w_addr;
        w_data_n    = '0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    req_n.wreg  = in_wreg;
                    req_n.wd    = in_wd;
                    req_n.op    = in_mem_op;
                    req_n.addr  = in_mem_addr;
                    req_n.sdata = in_store_data;
                    cnt_n       = '0;
                    rbuf_n      = '0;
                    if (op_len(in_mem_op) != 3'd0) begin
                        state_n     = ACCESS;
                        mem_req_n   = 1'b1;
                        mem_we_n    = is_store(in_mem_op);
                        mem_addr_n  = in_mem_addr;
                        mem_wdata_n = in_store_data[7:0];
                        stall_n     = 1'b1;
                    end else begin
                        state_n    = DONE;
                        wb_valid_n = 1'b1;
                        w_enable_n = in_wreg;
                        w_addr_n   = in_wd;
                        w_data_n   = in_wdata;
                    end
                end
            end
            ACCESS: begin
                if (mem_req && mem_ack) begin
                    if (!mem_we) rbuf_n[rd_idx +: 8] = mem_rdata;
                    if ({1'b0, cnt} == op_len(req.op) - 3'd1) begin
                        state_n    = DONE;
                        mem_req_n  = 1'b0;
                        mem_we_n   = 1'b0;
                        stall_n    = 1'b0;
                        wb_valid_n = 1'b1;
                        w_addr_n   = req.wd;
                        if (!is_store(req.op)) begin
                            w_enable_n = req.wreg;
                            // rbuf_n already holds the byte arriving this edge.
                            w_data_n   = load_ext(req.op, rbuf_n);
                        end
                    end else begin
                        cnt_n       = cnt + 2'd1;
                        mem_addr_n  = req.addr + ADDR_W'(cnt + 2'd1);
                        mem_wdata_n = sdata_w[nx_idx +: 8];
                    end
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 5-stage RV32I pipeline, between EX and the MEM/WB path into the register file write port (w_enable/w_addr/w_data).
- Executes loads and stores over the 8-bit byte-serial memory port using a multi-cycle state machine.
- Passes ALU results through for non-memory ops.
- Raises stall_req while a memory access is in flight.

Parameters:
- ADDR_W, 32, memory address width.
- DATA_W, 32, register data width (RegBus).
- REG_AW, 5, register address width (RegAddrBus).

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-low (rst==0 at a clk rising edge resets the block).
- in_valid  in  1  EX result valid.
- in_ready  out  1  stage can accept; combinational, equals (state==IDLE).
- in_wreg  in  1  instruction writes rd.
- in_wd  in  REG_AW  rd address.
- in_wdata  in  DATA_W  ALU result (non-memory ops).
- in_mem_op  in  4  0 NONE, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 6 SB, 7 SH, 8 SW; 9–15 treated as NONE.
- in_mem_addr  in  ADDR_W  effective address.
- in_store_data  in  DATA_W  store source (rs2).
- mem_req  out  1  byte request.
- mem_we  out  1  1 = write.
- mem_addr  out  ADDR_W  byte address.
- mem_wdata  out  8  store byte.
- mem_ack  in  1  byte transfer complete.
- mem_rdata  in  8  read byte; valid with mem_ack.
- stall_req  out  1  freeze upstream stages.
- wb_valid  out  1  one-cycle retire pulse.
- w_enable  out  1  register write enable.
- w_addr  out  REG_AW  register write address.
- w_data  out  DATA_W  register write data.

Behaviour:
- Reset: state IDLE.
  - mem_req, mem_we, mem_wdata, mem_addr, wb_valid, w_enable, w_addr, w_data, stall_req, and the byte counter all 0.
  - Reset mid-access abandons the transaction; mem_ack in the reset cycle is ignored.
- States: IDLE, ACCESS, DONE.
- Accept: in_valid && in_ready at a clk edge latches all in_* fields.
- Non-memory op: IDLE -> DONE.
  - Next cycle: wb_valid=1, w_enable=in_wreg, w_addr=in_wd, w_data=in_wdata.
  - Latency 1 cycle.
- Memory op: IDLE -> ACCESS.
  - Byte count N = 1 for B/BU, 2 for H/HU, 4 for W.
  - mem_req rises the cycle after accept.
  - Byte k (k = 0..N-1) uses address in_mem_addr+k, modulo 2^ADDR_W; addresses wrap.
  - Little-endian; no alignment restriction.
- Request hold rule:
  - mem_req, mem_we, mem_addr and mem_wdata are registered and stay stable until a cycle with mem_ack=1.
  - On an acked edge the counter advances; the next byte is presented the following cycle with mem_req kept high.
  - mem_ack may arrive in the first cycle mem_req is high (zero-wait memory).
  - mem_ack while mem_req=0 is ignored.
- Stores: mem_we=1, mem_wdata = store_data[8k+7:8k].
- Loads: mem_we=0; the byte from mem_rdata on the acked edge is written into buffer byte k.
- After the Nth ack: ACCESS -> DONE; mem_req=0 in DONE.
  - Load: w_enable=in_wreg, w_data = buffer, extended to DATA_W.
    - LB/LH sign-extend from bit 7/15.
    - LBU/LHU zero-extend.
  - Store: w_enable=0, w_data=0.
  - In all cases wb_valid=1.
  - With zero-wait memory, a memory op takes N+1 cycles from accept to the wb_valid cycle.
- DONE -> IDLE after one cycle; wb_valid, w_enable and w_data deassert (w_data=0) unless a new retire occurs.
- in_ready is 0 in ACCESS and DONE; the upstream must hold its inputs.
- stall_req: registered; 1 in every ACCESS cycle, 0 in IDLE and DONE.
- w_addr=0 is forwarded unchanged; x0 suppression is done downstream.
- An unused opcode behaves as NONE.

Test Plan:
- ALU pass-through: in_mem_op=0, wreg=1, wd=5, wdata=0x1234ABCD -> next cycle wb_valid=1, w_enable=1, w_addr=5, w_data=0x1234ABCD; mem_req never rises.
- LW at 0x100, zero-wait, bytes 0x78,0x56,0x34,0x12 -> mem_addr 0x100..0x103 on consecutive cycles; w_data=0x12345678 four cycles after mem_req rises; stall_req=1 exactly 4 cycles.
- LB 0x80 -> w_data=0xFFFFFF80; LBU 0x80 -> 0x00000080; LH 0x8001 (bytes 0x01,0x80) -> 0xFFFF8001.
- SH data 0xDEADBEEF at 0x200, ack delayed 3 cycles per byte -> writes 0xEF@0x200 then 0xBE@0x201; request fields held constant until each ack; wb_valid=1 with w_enable=0.
- LW at 0xFFFFFFFE -> mem_addr 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1.
- rst=0 after the second byte ack of an LW -> next cycle mem_req=0, stall_req=0, wb_valid=0, state IDLE; a following ALU op retires normally.
